// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, shared-memory and status signals of mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      instr_req_i;
    logic [ADDR_WIDTH-1:0]     instr_addr_i;
    logic                      instr_gnt_o;
    logic                      instr_rvalid_o;
    logic [DATA_WIDTH-1:0]     instr_rdata_o;
    logic                      data_req_i;
    logic [ADDR_WIDTH-1:0]     data_addr_i;
    logic                      data_we_i;
    logic [DATA_WIDTH/8-1:0]   data_be_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic                      data_gnt_o;
    logic                      data_rvalid_o;
    logic [DATA_WIDTH-1:0]     data_rdata_o;
    logic                      data_err_o;
    logic                      mem_req_o;
    logic [ADDR_WIDTH-1:0]     mem_addr_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic                      mem_gnt_i;
    logic                      mem_rvalid_i;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;
    logic                      mem_err_i;
    logic                      busy_o;
    logic                      spurious_rvalid_o;
    modport slave (
        input  instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
               data_err_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, busy_o, spurious_rvalid_o
    );
    modport master (
        output instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
               data_err_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, busy_o, spurious_rvalid_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one in-order memory port between instr fetch and LSU, routing responses by grant order.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority over instr.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, WAIT_GNT} state_e;
    localparam int BE_W = DATA_WIDTH / 8;
    state_e                     state_q, state_d;
    logic                       owner_q, owner_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [2:0]                 count_q, count_d;
    logic                       spurious_q, spurious_d;
    logic                       sel, mreq, full, empty, xfer, pop;
    logic [ADDR_WIDTH-1:0]      addr_sel;
`ifdef ARB_ROUND_ROBIN_EN
    logic                       last_q, last_d;
`endif
    // sel: 0 = instr, 1 = data; fifo bit 0 is the owner of the oldest outstanding transaction
    always_comb begin
        full  = count_q == 3'(MAX_OUTSTANDING);
        empty = count_q == 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
        sel = state_q == WAIT_GNT ? owner_q :
              (bus.instr_req_i & bus.data_req_i) ? ~last_q : bus.data_req_i;
        last_d = xfer ? sel : last_q;
`else
        sel = state_q == WAIT_GNT ? owner_q : bus.data_req_i;
`endif
        mreq     = rst_ni & ~full & (sel ? bus.data_req_i : bus.instr_req_i);
        xfer     = mreq & bus.mem_gnt_i;
        pop      = rst_ni & bus.mem_rvalid_i & ~empty;
        addr_sel = sel ? bus.data_addr_i : bus.instr_addr_i;
        bus.mem_req_o      = mreq;
        bus.mem_addr_o     = addr_sel;
        bus.mem_we_o       = sel & bus.data_we_i;
        bus.mem_be_o       = sel ? bus.data_be_i : {BE_W{1'b1}};
        bus.mem_wdata_o    = sel ? bus.data_wdata_i : {DATA_WIDTH{1'b0}};
        bus.instr_gnt_o    = xfer & ~sel;
        bus.data_gnt_o     = xfer & sel;
        bus.instr_rvalid_o = pop & ~fifo_q[0];
        bus.data_rvalid_o  = pop & fifo_q[0];
        bus.data_err_o     = pop & fifo_q[0] & bus.mem_err_i;
        bus.instr_rdata_o  = bus.mem_rdata_i;
        bus.data_rdata_o   = bus.mem_rdata_i;
        bus.busy_o         = ~empty | bus.instr_req_i | bus.data_req_i;
        bus.spurious_rvalid_o = spurious_q;
        state_d    = (mreq & ~bus.mem_gnt_i) ? WAIT_GNT : IDLE;
        owner_d    = sel;
        count_d    = count_q + {2'b0, xfer} - {2'b0, pop};
        spurious_d = spurious_q | (bus.mem_rvalid_i & empty);
        fifo_d     = pop ? fifo_q >> 1 : fifo_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (xfer && 3'(i) == count_q - {2'b0, pop}) fifo_d[i] = sel;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            fifo_q     <= '0;
            count_q    <= 3'd0;
            spurious_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports; byte enables are DATA_WIDTH/8 wide.
REQ-003 Parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered transactions (legal 1..4).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 instr_req_i / instr_addr_i  in  1 / ADDR_WIDTH  instruction fetch request and address (read-only).
REQ-007 instr_gnt_o / instr_rvalid_o / instr_rdata_o  out  1 / 1 / DATA_WIDTH  fetch grant, response valid, read data.
REQ-008 data_req_i / data_addr_i / data_we_i / data_be_i / data_wdata_i  in  1 / ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH  LSU request.
REQ-009 data_gnt_o / data_rvalid_o / data_rdata_o / data_err_o  out  1 / 1 / DATA_WIDTH / 1  LSU grant, response valid, data, error.
REQ-010 mem_req_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  shared memory request bundle.
REQ-011 mem_gnt_i / mem_rvalid_i / mem_rdata_i / mem_err_i  in  shared memory grant and response.
REQ-012 busy_o  out  1  high while any transaction is outstanding or any request is pending.
REQ-013 spurious_rvalid_o  out  1  sticky flag: mem_rvalid_i seen with no outstanding transaction.

Function
REQ-014 Transfer SHALL occur in a cycle with mem_req_o and mem_gnt_i both high; the selected requester's gnt_o equals mem_gnt_i & mem_req_o, the other gnt_o is 0.
REQ-015 Request path SHALL be combinational (zero latency) from requester req to mem_req_o; instr selection drives mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
REQ-016 FSM states IDLE, WAIT_GNT: IDLE->WAIT_GNT when mem_req_o high and mem_gnt_i low; WAIT_GNT->IDLE on grant.
REQ-017 In WAIT_GNT the owner and its bundle SHALL remain selected until granted; no switching to the other requester.
REQ-018 An owner FIFO, depth MAX_OUTSTANDING, SHALL push the granted requester ID on each transfer and pop on mem_rvalid_i.
REQ-019 mem_rvalid_i SHALL be routed combinationally to the FIFO-head owner's rvalid_o; rdata is broadcast to both ports, qualified only by rvalid_o.
REQ-020 data_err_o = mem_err_i & data_rvalid_o; mem_err_i on an instr response is dropped.
REQ-021 FIFO full: mem_req_o=0 and both gnt_o=0, even in a cycle where mem_rvalid_i pops an entry.
REQ-022 mem_rvalid_i with FIFO empty: no rvalid_o asserted, spurious_rvalid_o set and held until reset.
REQ-023 Simultaneous push and pop when not full: count unchanged, ordering preserved.
REQ-024 Responses SHALL be returned in grant order; the memory is in-order.

Reset
REQ-025 rst_ni low at a clock edge: FIFO emptied, count 0, FSM IDLE, spurious_rvalid_o 0, round-robin pointer = "instr last granted".
REQ-026 While rst_ni is low, mem_req_o, both gnt_o, both rvalid_o, data_err_o SHALL be 0.
REQ-027 Reset mid-operation SHALL discard outstanding transactions; later mem_rvalid_i sets spurious_rvalid_o.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: in IDLE with both requesting, the port not granted most recently wins; pointer updates on each transfer.
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, data always beats instr; pointer logic absent.

Verification
REQ-030 Instr-only read of 0x20, mem_gnt_i same cycle, rvalid 2 cycles later with 0xDEADBEEF -> instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 with rdata 0xDEADBEEF in cycle 2.
REQ-031 Both request in same cycle from reset -> data granted first; with ARB_ROUND_ROBIN_EN, instr granted next cycle; without it, instr starved while data_req_i stays high.
REQ-032 mem_gnt_i held low 3 cycles with data write 0x100/be 0x3, instr_req_i raised meanwhile -> mem bundle stable for all 3 cycles, instr_gnt_o stays 0.
REQ-033 MAX_OUTSTANDING=2, two grants (instr then data) with no rvalid -> third request blocked (mem_req_o=0); first rvalid goes to instr, second to data with mem_err_i=1 giving data_err_o=1.
REQ-034 mem_rvalid_i pulsed with FIFO empty -> no rvalid_o, spurious_rvalid_o=1 until rst_ni low; rst_ni low with 1 outstanding -> busy_o=0 next cycle.
